pipe_stage_reg: RTL and testbench

- Parametrised, handshaked pipeline stage register. Successor to the fixed-field inter-stage registers between IF/ID/EX/MEM/WB.
- Carries an opaque data payload and a control vector with a valid/ready handshake.
- Optional 2-entry skid buffer gives full throughput with a registered in_ready.
- Separates three controls: hold (freeze), bubble (accept nothing, keep draining) and flush (kill contents). Invalid slots present a parametrised safe control value instead of X.

---
 rtl/pipe_pkg.sv | 30 +++
 rtl/pipe_slot.sv | 37 +++
 rtl/pipe_stage_reg.sv | 120 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared constants for the inter-stage pipeline registers: control bit
// positions, the safe control value and the payload field layout.
package pipe_pkg;

  localparam int unsigned DATA_W_DEFAULT = 160;
  localparam int unsigned CTRL_W_DEFAULT = 3;

  localparam int unsigned CTRL_WR_REG_N = 0;
  localparam int unsigned CTRL_WR_CSR_N = 1;
  localparam int unsigned CTRL_FLUSH    = 2;

  localparam logic [2:0] CTRL_SAFE_DEFAULT = 3'b011;

  // Payload layout shared by the ID/EX, EX/MEM and MEM/WB instances
  localparam int unsigned FIELD_W  = 32;
  localparam int unsigned OFS_PC   = 0;
  localparam int unsigned OFS_PC4  = 32;
  localparam int unsigned OFS_OP_A = 64;
  localparam int unsigned OFS_OP_B = 96;
  localparam int unsigned OFS_IMM  = 128;

  typedef struct packed {
    logic [FIELD_W-1:0] imm;
    logic [FIELD_W-1:0] op_b;
    logic [FIELD_W-1:0] op_a;
    logic [FIELD_W-1:0] pc4;
    logic [FIELD_W-1:0] pc;
  } stage_payload_t;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline slot: valid flag plus payload and control registers.
// Clear beats hold, hold beats load; data is kept when the slot empties.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int unsigned        DATA_W    = DATA_W_DEFAULT,
  parameter int unsigned        CTRL_W    = CTRL_W_DEFAULT,
  parameter logic [CTRL_W-1:0]  CTRL_SAFE = CTRL_W'(CTRL_SAFE_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic              hold,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [CTRL_W-1:0] ld_ctrl,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
      ctrl  <= CTRL_SAFE;
    end else if (clear) begin
      valid <= 1'b0;
      ctrl  <= CTRL_SAFE;
    end else if (!hold && load) begin
      valid <= 1'b1;
      data  <= ld_data;
      ctrl  <= ld_ctrl;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with optional two-entry skid buffer,
// separate hold / bubble / flush controls and a safe control value when empty.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned        DATA_W    = DATA_W_DEFAULT,
  parameter int unsigned        CTRL_W    = CTRL_W_DEFAULT,
  parameter logic [CTRL_W-1:0]  CTRL_SAFE = CTRL_W'(CTRL_SAFE_DEFAULT),
  parameter bit                 SKID      = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              bubble,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        count
);

  logic              head_valid;
  logic [DATA_W-1:0] head_data;
  logic [CTRL_W-1:0] head_ctrl;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;

  logic              open_c;
  logic              accept;
  logic              emit;
  logic              head_load;
  logic              head_clear;
  logic              skid_load;
  logic              skid_clear;
  logic [DATA_W-1:0] head_ld_data;
  logic [CTRL_W-1:0] head_ld_ctrl;

  // Reset also masks the output so a reset never looks like an emit
  assign open_c    = rst_n & ~hold & ~bubble & ~flush;
  assign out_valid = rst_n & head_valid & ~hold;
  assign out_ctrl  = out_valid ? head_ctrl : CTRL_SAFE;
  assign out_data  = head_data;
  assign accept    = in_valid & in_ready;
  assign emit      = out_valid & out_ready;
  assign count     = 2'(head_valid) + 2'(skid_valid);

  // Slot steering: skid refills head first, otherwise new beats go to head if it frees up
  always_comb begin
    head_load    = 1'b0;
    head_clear   = 1'b0;
    skid_load    = 1'b0;
    skid_clear   = 1'b0;
    head_ld_data = in_data;
    head_ld_ctrl = in_ctrl;
    if (emit && skid_valid) begin
      head_load    = 1'b1;
      head_ld_data = skid_data;
      head_ld_ctrl = skid_ctrl;
      skid_clear   = 1'b1;
    end else if (accept && (!head_valid || emit)) begin
      head_load = 1'b1;
    end else if (accept) begin
      skid_load = 1'b1;
    end else if (emit) begin
      head_clear = 1'b1;
    end
  end

  pipe_slot #(
    .DATA_W    (DATA_W),
    .CTRL_W    (CTRL_W),
    .CTRL_SAFE (CTRL_SAFE)
  ) u_head (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (head_load),
    .clear   (flush | head_clear),
    .hold    (hold),
    .ld_data (head_ld_data),
    .ld_ctrl (head_ld_ctrl),
    .valid   (head_valid),
    .data    (head_data),
    .ctrl    (head_ctrl)
  );

  if (SKID) begin : g_skid
    pipe_slot #(
      .DATA_W    (DATA_W),
      .CTRL_W    (CTRL_W),
      .CTRL_SAFE (CTRL_SAFE)
    ) u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (skid_load),
      .clear   (flush | skid_clear),
      .hold    (hold),
      .ld_data (in_data),
      .ld_ctrl (in_ctrl),
      .valid   (skid_valid),
      .data    (skid_data),
      .ctrl    (skid_ctrl)
    );
    // Depends only on registered skid occupancy, not on out_ready
    assign in_ready = open_c & ~skid_valid;
  end else begin : g_no_skid
    logic unused_skid_c;
    assign skid_valid    = 1'b0;
    assign skid_data     = '0;
    assign skid_ctrl     = CTRL_SAFE;
    assign unused_skid_c = skid_load ^ skid_clear;
    assign in_ready      = open_c & (~head_valid | out_ready);
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a FIFO-queue model checks a SKID=1 and a SKID=0
// instance every cycle, plus directed scenarios with literal expectations.
module tb_pipe_stage_reg;

  localparam int unsigned DW = 160;
  localparam int unsigned CW = 3;
  localparam logic [CW-1:0] SAFE = 3'b011;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } beat_t;

  logic clk = 1'b0;
  initial forever #5 clk = ~clk;

  logic          rst_n     [2];
  logic          hold      [2];
  logic          bubble    [2];
  logic          flush     [2];
  logic          in_valid  [2];
  logic          in_ready  [2];
  logic [DW-1:0] in_data   [2];
  logic [CW-1:0] in_ctrl   [2];
  logic          out_valid [2];
  logic          out_ready [2];
  logic [DW-1:0] out_data  [2];
  logic [CW-1:0] out_ctrl  [2];
  logic [1:0]    count     [2];

  // Instance 1 has the skid buffer, instance 0 does not
  for (genvar k = 0; k < 2; k++) begin : g_dut
    pipe_stage_reg #(
      .DATA_W    (DW),
      .CTRL_W    (CW),
      .CTRL_SAFE (SAFE),
      .SKID      (k == 1)
    ) dut (
      .clk       (clk),
      .rst_n     (rst_n[k]),
      .hold      (hold[k]),
      .bubble    (bubble[k]),
      .flush     (flush[k]),
      .in_valid  (in_valid[k]),
      .in_ready  (in_ready[k]),
      .in_data   (in_data[k]),
      .in_ctrl   (in_ctrl[k]),
      .out_valid (out_valid[k]),
      .out_ready (out_ready[k]),
      .out_data  (out_data[k]),
      .out_ctrl  (out_ctrl[k]),
      .count     (count[k])
    );
  end

  int unsigned   n_pass = 0;
  int unsigned   n_chk  = 0;
  int            cyc    = 0;
  bit            chk_en = 1'b0;
  beat_t         mq   [2][$];
  logic [DW-1:0] mhd  [2];
  logic [DW-1:0] elog [2][$];
  logic [DW-1:0] alog0[$];
  int            ecyc[$];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  // Model: each stage is a FIFO of capacity 2 (skid) or 1 (no skid)
  function automatic bit exp_in_ready(int k);
    if (!rst_n[k] || hold[k] || bubble[k] || flush[k]) return 1'b0;
    if (k == 1) return mq[k].size() < 2;
    return (mq[k].size() == 0) || out_ready[k];
  endfunction

  function automatic bit exp_out_valid(int k);
    return rst_n[k] && (mq[k].size() > 0) && !hold[k];
  endfunction

  function automatic logic [CW-1:0] exp_out_ctrl(int k);
    return exp_out_valid(k) ? mq[k][0].c : SAFE;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 2; k++) begin
      bit acc;
      bit emt;
      acc = in_valid[k] && exp_in_ready(k);
      emt = exp_out_valid(k) && out_ready[k];
      if (!rst_n[k]) begin
        mq[k].delete();
        mhd[k] = '0;
      end else if (flush[k]) begin
        mq[k].delete();
      end else if (!hold[k]) begin
        if (emt) void'(mq[k].pop_front());
        if (acc) mq[k].push_back(beat_t'{in_data[k], in_ctrl[k]});
      end
      if (mq[k].size() > 0) mhd[k] = mq[k][0].d;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("in_ready[%0d]", k), DW'(in_ready[k]), DW'(exp_in_ready(k)));
        check($sformatf("out_valid[%0d]", k), DW'(out_valid[k]), DW'(exp_out_valid(k)));
        check($sformatf("out_ctrl[%0d]", k), DW'(out_ctrl[k]), DW'(exp_out_ctrl(k)));
        check($sformatf("out_data[%0d]", k), out_data[k], mhd[k]);
        check($sformatf("count[%0d]", k), DW'(count[k]), DW'(mq[k].size()));
        if (out_valid[k] && out_ready[k]) begin
          elog[k].push_back(out_data[k]);
          if (k == 1) ecyc.push_back(cyc);
        end
        if (k == 0 && in_valid[0] && in_ready[0]) alog0.push_back(in_data[0]);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    int t0;
    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b0; hold[k] = 1'b0; bubble[k] = 1'b0; flush[k] = 1'b0;
      in_valid[k] = 1'b0; out_ready[k] = 1'b0; in_data[k] = '0; in_ctrl[k] = SAFE;
    end
    tick(1);
    chk_en = 1'b1;
    tick(1);
    #1;
    check("rst_count", DW'(count[1]), DW'(0));
    check("rst_in_ready", DW'(in_ready[1]), DW'(0));
    check("rst_out_ctrl", DW'(out_ctrl[1]), DW'(SAFE));
    check("rst_out_data", out_data[1], DW'(0));
    for (int k = 0; k < 2; k++) rst_n[k] = 1'b1;
    #1;
    check("post_rst_in_ready", DW'(in_ready[1]), DW'(1));

    // Streaming with the skid instance
    out_ready[1] = 1'b1;
    in_ctrl[1]   = 3'b000;
    t0 = cyc;
    for (int i = 1; i <= 8; i++) begin
      in_valid[1] = 1'b1;
      in_data[1]  = DW'(i);
      tick(1);
    end
    in_valid[1] = 1'b0;
    in_ctrl[1]  = SAFE;
    tick(2);
    check("stream_n", DW'(elog[1].size()), DW'(8));
    for (int i = 0; i < elog[1].size() && i < 8; i++)
      check($sformatf("stream_data%0d", i), elog[1][i], DW'(i + 1));
    if (ecyc.size() == 8) begin
      check("stream_latency", DW'(ecyc[0]), DW'(t0 + 1));
      check("stream_back2back", DW'(ecyc[7] - ecyc[0]), DW'(7));
    end

    // Skid fill with downstream stalled, then drain in order
    elog[1].delete();
    out_ready[1] = 1'b0;
    in_valid[1]  = 1'b1;
    in_data[1]   = DW'('hA1);
    tick(1);
    in_data[1]   = DW'('hA2);
    tick(1);
    in_valid[1]  = 1'b0;
    #1;
    check("skid_count", DW'(count[1]), DW'(2));
    check("skid_in_ready", DW'(in_ready[1]), DW'(0));
    out_ready[1] = 1'b1;
    tick(1);
    #1;
    check("skid_drain_ready", DW'(in_ready[1]), DW'(1));
    tick(2);
    check("skid_emit_n", DW'(elog[1].size()), DW'(2));
    if (elog[1].size() == 2) begin
      check("skid_first", elog[1][0], DW'('hA1));
      check("skid_second", elog[1][1], DW'('hA2));
    end

    // Hold freezes the head and masks the output
    elog[1].delete();
    out_ready[1] = 1'b0;
    in_valid[1]  = 1'b1;
    in_data[1]   = DW'('hB0);
    in_ctrl[1]   = 3'b100;
    tick(1);
    in_valid[1]  = 1'b0;
    in_ctrl[1]   = SAFE;
    hold[1]      = 1'b1;
    out_ready[1] = 1'b1;
    repeat (3) begin
      #1;
      check("hold_valid", DW'(out_valid[1]), DW'(0));
      check("hold_ctrl", DW'(out_ctrl[1]), DW'(SAFE));
      check("hold_data", out_data[1], DW'('hB0));
      tick(1);
    end
    hold[1] = 1'b0;
    #1;
    check("release_valid", DW'(out_valid[1]), DW'(1));
    check("release_ctrl", DW'(out_ctrl[1]), DW'(3'b100));
    tick(1);
    check("hold_emit_n", DW'(elog[1].size()), DW'(1));
    if (elog[1].size() == 1) check("hold_emit_data", elog[1][0], DW'('hB0));

    // Bubble drains the head and refuses new input
    elog[1].delete();
    out_ready[1] = 1'b0;
    in_valid[1]  = 1'b1;
    in_data[1]   = DW'('hC0);
    in_ctrl[1]   = 3'b000;
    tick(1);
    bubble[1]    = 1'b1;
    in_data[1]   = DW'('hDD);
    out_ready[1] = 1'b1;
    #1;
    check("bubble_in_ready", DW'(in_ready[1]), DW'(0));
    repeat (2) begin
      tick(1);
      #1;
      check("bubble_valid", DW'(out_valid[1]), DW'(0));
      check("bubble_ctrl", DW'(out_ctrl[1]), DW'(SAFE));
    end
    in_valid[1] = 1'b0;
    in_ctrl[1]  = SAFE;
    bubble[1]   = 1'b0;
    tick(1);
    check("bubble_emit_n", DW'(elog[1].size()), DW'(1));
    if (elog[1].size() == 1) check("bubble_emit_data", elog[1][0], DW'('hC0));

    // Flush with both slots full; flush-cycle input is dropped
    elog[1].delete();
    out_ready[1] = 1'b0;
    in_valid[1]  = 1'b1;
    in_data[1]   = DW'('hE1);
    tick(1);
    in_data[1]   = DW'('hE2);
    tick(1);
    #1;
    check("flush_full", DW'(count[1]), DW'(2));
    flush[1]   = 1'b1;
    in_data[1] = DW'('hE3);
    tick(1);
    flush[1]    = 1'b0;
    in_valid[1] = 1'b0;
    #1;
    check("flush_count", DW'(count[1]), DW'(0));
    check("flush_ctrl", DW'(out_ctrl[1]), DW'(SAFE));
    check("flush_valid", DW'(out_valid[1]), DW'(0));
    out_ready[1] = 1'b1;
    tick(2);
    check("flush_emit_n", DW'(elog[1].size()), DW'(0));

    // No-skid instance with toggling out_ready, then reset mid-stream
    for (int i = 0; i < 10; i++) begin
      out_ready[0] = (i % 2 == 0);
      in_valid[0]  = 1'b1;
      in_data[0]   = DW'(alog0.size() + 1);
      tick(1);
    end
    rst_n[0] = 1'b0;
    tick(1);
    #1;
    check("rst0_count", DW'(count[0]), DW'(0));
    check("rst0_ctrl", DW'(out_ctrl[0]), DW'(SAFE));
    check("rst0_valid", DW'(out_valid[0]), DW'(0));
    rst_n[0]    = 1'b1;
    in_valid[0] = 1'b0;
    tick(1);
    check("noskid_accept_n", DW'(alog0.size()), DW'(5));
    check("noskid_emit_n", DW'(elog[0].size()), DW'(4));
    for (int i = 0; i < elog[0].size() && i < 4; i++)
      check($sformatf("noskid_data%0d", i), elog[0][i], DW'(i + 1));

    tick(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
